// File: rtl/weight_load_sequencer_if.sv
// Request, weight-buffer read port and quad-MAC chain-input bundle of the weight-load sequencer.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface weight_load_sequencer_if #(
   parameter int BUFFER_ADDR_WIDTH = 15
);
   logic                         start_i;
   logic [BUFFER_ADDR_WIDTH-1:0] base_addr_i;
   logic                         abort_i;
   logic                         ready_o;
   logic                         done_o;
   logic                         o_buf_rd_en;
   logic [BUFFER_ADDR_WIDTH-1:0] o_buf_rd_addr;
   logic [63:0]                  i_buf_rd_data;
   logic                         prepare_weight_o;
   logic                         set_weight_o;
   logic [7:0]                   o_load_weight_data_a_0;
   logic [7:0]                   o_load_weight_data_b_0;
   logic [7:0]                   o_load_weight_data_c_0;
   logic [7:0]                   o_load_weight_data_d_0;
   logic [7:0]                   o_load_weight_data_a_1;
   logic [7:0]                   o_load_weight_data_b_1;
   logic [7:0]                   o_load_weight_data_c_1;
   logic [7:0]                   o_load_weight_data_d_1;

   modport master (
      input  start_i, base_addr_i, abort_i, i_buf_rd_data,
      output ready_o, done_o, o_buf_rd_en, o_buf_rd_addr, prepare_weight_o, set_weight_o,
             o_load_weight_data_a_0, o_load_weight_data_b_0,
             o_load_weight_data_c_0, o_load_weight_data_d_0,
             o_load_weight_data_a_1, o_load_weight_data_b_1,
             o_load_weight_data_c_1, o_load_weight_data_d_1
   );

   modport slave (
      output start_i, base_addr_i, abort_i, i_buf_rd_data,
      input  ready_o, done_o, o_buf_rd_en, o_buf_rd_addr, prepare_weight_o, set_weight_o,
             o_load_weight_data_a_0, o_load_weight_data_b_0,
             o_load_weight_data_c_0, o_load_weight_data_d_0,
             o_load_weight_data_a_1, o_load_weight_data_b_1,
             o_load_weight_data_c_1, o_load_weight_data_d_1
   );
endinterface

// File: rtl/weight_load_sequencer.sv
// Weight-load sequencer: reads DEPTH words from the weight buffer, shifts them into stage 0 of the
// quad-MAC chain with prepare_weight high, then pulses set_weight so every stage latches its weight.
module weight_load_sequencer #(
   parameter int DEPTH             = 16,
   parameter int BUFFER_ADDR_WIDTH = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   weight_load_sequencer_if.master        bus
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_SET} state_t;

   state_t                       r_state, w_state_nxt;
   logic [CW-1:0]                r_cnt, w_cnt_nxt;
   logic [BUFFER_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic                         r_rd_en, w_rd_en_nxt;
   logic                         r_rd_valid, w_rd_valid_nxt;
   logic                         r_prepare, w_prepare_nxt;
   logic                         r_set, w_set_nxt;
   logic                         r_ready, w_ready_nxt;
   logic [63:0]                  r_data, w_data_nxt;
   logic                         w_abort;

   // Abort only has an effect while a load is in progress.
   assign w_abort = bus.abort_i && (r_state != S_IDLE);

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_rd_en_nxt = 1'b0;
      w_set_nxt   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start_i && !bus.abort_i) begin
               w_state_nxt = S_READ;
               w_addr_nxt  = bus.base_addr_i;
               w_cnt_nxt   = '0;
               w_rd_en_nxt = 1'b1;
            end
         end
         S_READ: begin
            if (r_cnt == CW'(DEPTH - 1)) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
               w_addr_nxt  = r_addr + 1'b1;
               w_rd_en_nxt = 1'b1;
            end
         end
         S_DRAIN: begin
            // Two cycles: the last read's data arrives, then is presented on the chain.
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_SET;
               w_cnt_nxt   = '0;
               w_set_nxt   = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_SET: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_abort) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_rd_en_nxt = 1'b0;
         w_set_nxt   = 1'b0;
      end

      w_ready_nxt    = (w_state_nxt == S_IDLE);
      // A read issued in the abort cycle is dropped before its data can reach the chain.
      w_rd_valid_nxt = r_rd_en && !w_abort;
      w_prepare_nxt  = r_rd_valid && !w_abort;
      w_data_nxt     = w_prepare_nxt ? bus.i_buf_rd_data : 64'd0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_rd_en    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_prepare  <= 1'b0;
         r_set      <= 1'b0;
         r_ready    <= 1'b1;
         r_data     <= 64'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_addr     <= w_addr_nxt;
         r_rd_en    <= w_rd_en_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_prepare  <= w_prepare_nxt;
         r_set      <= w_set_nxt;
         r_ready    <= w_ready_nxt;
         r_data     <= w_data_nxt;
      end
   end

   assign bus.ready_o          = r_ready;
   assign bus.done_o           = r_set;
   assign bus.set_weight_o     = r_set;
   assign bus.prepare_weight_o = r_prepare;
   assign bus.o_buf_rd_en      = r_rd_en;
   assign bus.o_buf_rd_addr    = r_addr;

   assign bus.o_load_weight_data_a_0 = r_data[7:0];
   assign bus.o_load_weight_data_b_0 = r_data[15:8];
   assign bus.o_load_weight_data_c_0 = r_data[23:16];
   assign bus.o_load_weight_data_d_0 = r_data[31:24];
   assign bus.o_load_weight_data_a_1 = r_data[39:32];
   assign bus.o_load_weight_data_b_1 = r_data[47:40];
   assign bus.o_load_weight_data_c_1 = r_data[55:48];
   assign bus.o_load_weight_data_d_1 = r_data[63:56];
endmodule

// File: tb/tb_weight_load_sequencer.sv
// Bench for weight_load_sequencer: directed loads plus random start/abort/reset traffic, every output
// compared each cycle against a cycle-offset model of one load (offset 0 = accept cycle).
module tb_weight_load_sequencer;
   localparam int DEPTH = 4;
   localparam int AW    = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   weight_load_sequencer_if #(.BUFFER_ADDR_WIDTH(AW)) bus ();

   weight_load_sequencer #(.DEPTH(DEPTH), .BUFFER_ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [63:0] mem [0:(1<<AW)-1];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   // Model: idle, or busy at offset m_c cycles after the accept cycle.
   bit          m_busy  = 1'b0;
   bit          m_fresh = 1'b1;
   int          m_c     = 0;
   logic [AW-1:0] m_base = '0;

   // Buffer: answers a read seen in cycle n with data held across the edge that ends cycle n+1.
   bit            pend_v = 1'b0;
   logic [AW-1:0] pend_a = '0;
   always @(negedge clk) begin
      bus.i_buf_rd_data = pend_v ? mem[pend_a] : {$urandom, $urandom};
      pend_v = bus.o_buf_rd_en;
      pend_a = bus.o_buf_rd_addr;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      bit            e_rd, e_prep, e_set;
      logic [AW-1:0] a;
      logic [63:0]   e_data, chain;
      e_rd   = m_busy && m_c >= 1 && m_c <= DEPTH;
      e_prep = m_busy && m_c >= 3 && m_c <= DEPTH + 2;
      e_set  = m_busy && m_c == DEPTH + 3;
      a      = m_base + AW'(m_c - 3);
      e_data = e_prep ? mem[a] : 64'd0;
      chain  = {bus.o_load_weight_data_d_1, bus.o_load_weight_data_c_1,
                bus.o_load_weight_data_b_1, bus.o_load_weight_data_a_1,
                bus.o_load_weight_data_d_0, bus.o_load_weight_data_c_0,
                bus.o_load_weight_data_b_0, bus.o_load_weight_data_a_0};
      check("ready_o", 64'(bus.ready_o), 64'(!m_busy));
      check("rd_en", 64'(bus.o_buf_rd_en), 64'(e_rd));
      check("prepare_weight", 64'(bus.prepare_weight_o), 64'(e_prep));
      check("set_weight", 64'(bus.set_weight_o), 64'(e_set));
      check("done_o", 64'(bus.done_o), 64'(e_set));
      check("chain_data", chain, e_data);
      if (e_rd) begin
         a = m_base + AW'(m_c - 1);
         check("rd_addr", 64'(bus.o_buf_rd_addr), 64'(a));
      end else if (!m_busy && m_fresh) begin
         check("rd_addr_reset", 64'(bus.o_buf_rd_addr), 64'd0);
      end
   endtask

   // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model.
   task automatic cycle(input bit st, input logic [AW-1:0] b, input bit ab, input bit r);
      @(negedge clk);
      cyc++;
      check_outputs();
      rst             = r;
      bus.start_i     = st;
      bus.base_addr_i = b;
      bus.abort_i     = ab;
      if (r) begin
         m_busy  = 1'b0;
         m_fresh = 1'b1;
      end else if (m_busy) begin
         if (ab || m_c == DEPTH + 3) m_busy = 1'b0;
         else m_c++;
      end else if (st && !ab) begin
         m_busy  = 1'b1;
         m_c     = 1;
         m_base  = b;
         m_fresh = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] lb;
      for (int n = 0; n < (1 << AW); n++) begin
         lb = n[7:0];
         mem[n] = (n < 'h1000) ? {8{lb}} : {$urandom, $urandom};
      end
      mem['h100] = 64'h8877665544332211;
      bus.start_i       = 1'b0;
      bus.base_addr_i   = '0;
      bus.abort_i       = 1'b0;
      bus.i_buf_rd_data = 64'd0;

      // Reset, then quiet idle.
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
      repeat (10) cycle(1'b0, '0, 1'b0, 1'b0);

      // Plain load from 0x0010.
      cycle(1'b1, AW'('h10), 1'b0, 1'b0);
      repeat (7) cycle(1'b0, '0, 1'b0, 1'b0);

      // Address wrap, with a start pulse while busy that must be ignored.
      cycle(1'b1, AW'('h7FFE), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, AW'('h1234), 1'b0, 1'b0);
      repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);

      // Back-to-back start in the ready cycle; first word exercises the byte map.
      cycle(1'b1, AW'('h100), 1'b0, 1'b0);
      repeat (7) cycle(1'b0, '0, 1'b0, 1'b0);

      // Abort together with start in idle: start not accepted.
      cycle(1'b1, AW'('h200), 1'b1, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);

      // Abort at cycle 4, then a new load completes normally.
      cycle(1'b1, AW'('h20), 1'b0, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, AW'('h30), 1'b0, 1'b0);
      repeat (8) cycle(1'b0, '0, 1'b0, 1'b0);

      // Synchronous reset at cycle 5 of a load.
      cycle(1'b1, AW'('h40), 1'b0, 1'b0);
      repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      repeat (8) cycle(1'b0, '0, 1'b0, 1'b0);

      // Abort in the SET cycle suppresses nothing already shown but returns to idle.
      cycle(1'b1, AW'('h50), 1'b0, 1'b0);
      repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);

      // Random traffic.
      repeat (600) cycle($urandom_range(0, 3) == 0, AW'($urandom),
                         $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      repeat (10) cycle(1'b0, '0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
